// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with a BLANK/SHOW dwell per digit,
// fed by two round-robin arbitrated writers into a 4x4-bit digit store.
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req_a,
    input  logic [1:0] addr_a,
    input  logic [3:0] data_a,
    output logic       gnt_a,
    input  logic       req_b,
    input  logic [1:0] addr_b,
    input  logic [3:0] data_b,
    output logic       gnt_b,
    output logic [3:0] an,
    output logic [3:0] bcd,
    output logic [1:0] scan_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [15:0] SHOW_LAST  = 16'(DIV - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  regs [4];
    logic        prio_b;

    // Round-robin: a lone requester always wins; on contention the pointer decides.
    assign gnt_a = !rst && req_a && (!req_b || !prio_b);
    assign gnt_b = !rst && req_b && (!req_a || prio_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the digit store is reset because a blank-after-reset display is
            // observable behaviour, not just an initial-value nicety.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            prio_b <= 1'b0;
        end else if (gnt_a) begin
            regs[addr_a] <= data_a;
            prio_b       <= 1'b1;
        end else if (gnt_b) begin
            regs[addr_b] <= data_b;
            prio_b       <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            scan_idx <= '0;
            an       <= 4'b1111;
            bcd      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    an       <= 4'b1111;
                    scan_idx <= '0;
                    cnt      <= '0;
                    if (en) state <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (!en) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        scan_idx <= '0;
                        an       <= 4'b1111;
                    end else if (cnt == BLANK_LAST) begin
                        // NOTE: non-blocking read of regs yields the pre-write value
                        // when a grant targets this digit on the same edge.
                        state <= ST_SHOW;
                        cnt   <= '0;
                        bcd   <= regs[scan_idx];
                        an    <= ~(4'b0001 << scan_idx);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (!en) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        scan_idx <= '0;
                        an       <= 4'b1111;
                    end else if (cnt == SHOW_LAST) begin
                        state    <= ST_BLANK;
                        cnt      <= '0;
                        scan_idx <= scan_idx + 2'd1;
                        an       <= 4'b1111;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    scan_idx <= '0;
                    an       <= 4'b1111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (DIV=4, BLANK=2): directed stimulus pushes expected
// digit presentations into a queue that a negedge monitor drains and compares.
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst, en;
    logic       req_a, req_b, gnt_a, gnt_b;
    logic [1:0] addr_a, addr_b, scan_idx;
    logic [3:0] data_a, data_b, an, bcd;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] val;
    } disp_t;

    disp_t disp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    logic [3:0] prev_an = 4'hF;

    display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
        .an(an), .bcd(bcd), .scan_idx(scan_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input logic [3:0] val);
        disp_t e;
        e.idx = idx;
        e.val = val;
        disp_q.push_back(e);
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while (disp_q.size() != 0 && c < maxc) begin
            step();
            c++;
        end
        check("drain_timeout", disp_q.size(), 0);
        disp_q.delete();
    endtask

    task automatic wait_idx(input logic [1:0] v, input int maxc);
        int c = 0;
        while (scan_idx !== v && c < maxc) begin
            step();
            c++;
        end
        check("sync_scan_idx", scan_idx, v);
    endtask

    // Monitor: every SHOW onset (an leaving 1111) is a digit presentation.
    always @(negedge clk) begin
        if (mon_en) begin
            check("an_at_most_one_low", ($countones(~an) <= 1), 1);
            if (an != 4'hF && prev_an == 4'hF && disp_q.size() > 0) begin
                disp_t      e;
                logic [3:0] exp_an;
                e      = disp_q.pop_front();
                exp_an = ~(4'b0001 << e.idx);
                check("show_an", an, exp_an);
                check("show_scan_idx", scan_idx, e.idx);
                check("show_bcd", bcd, e.val);
            end
            prev_an = an;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_trace [10];
        exp_trace = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};

        rst = 1'b1; en = 1'b0;
        req_a = 1'b1; addr_a = 2'd0; data_a = 4'h9;
        req_b = 1'b0; addr_b = 2'd0; data_b = 4'h0;
        step(); step();
        check("rst_gnt_a", gnt_a, 0);
        check("rst_an", an, 4'hF);
        check("rst_bcd", bcd, 0);
        check("rst_scan_idx", scan_idx, 0);
        req_a = 1'b0;
        mon_en = 1'b1;

        // Reset release with en=1: 1 IDLE + 2 BLANK, digit 0 for 4, BLANK 2, digit 1.
        push(2'd0, 4'h0);
        push(2'd1, 4'h0);
        rst = 1'b0; en = 1'b1;
        check("trace_an_0", an, exp_trace[0]);
        for (int k = 1; k < 10; k++) begin
            step();
            check($sformatf("trace_an_%0d", k), an, exp_trace[k]);
        end

        // Lone write from A to digit 2.
        req_a = 1'b1; addr_a = 2'd2; data_a = 4'h7;
        #1;
        check("single_gnt_a", gnt_a, 1);
        check("single_gnt_b", gnt_b, 0);
        push(2'd2, 4'h7);
        step();
        req_a = 1'b0;
        wait_drain(60);

        // Contention right after reset: A first, then the held B request.
        rst = 1'b1; en = 1'b0;
        step(); step();
        rst = 1'b0;
        req_a = 1'b1; addr_a = 2'd0; data_a = 4'h3;
        req_b = 1'b1; addr_b = 2'd1; data_b = 4'h5;
        #1;
        check("both_gnt_a", gnt_a, 1);
        check("both_gnt_b", gnt_b, 0);
        step();
        req_a = 1'b0;
        #1;
        check("held_gnt_b", gnt_b, 1);
        check("held_gnt_a", gnt_a, 0);
        step();
        req_b = 1'b0;
        en = 1'b1;
        push(2'd0, 4'h3);
        push(2'd1, 4'h5);
        push(2'd2, 4'h0);
        push(2'd3, 4'h0);
        wait_drain(60);

        // Write digit 3 on the very edge it enters SHOW: old value now, new next pass.
        wait_idx(2'd2, 40);
        wait_idx(2'd3, 40);
        check("blank3_an", an, 4'hF);
        step();
        req_a = 1'b1; addr_a = 2'd3; data_a = 4'h9;
        push(2'd3, 4'h0);
        push(2'd0, 4'h3);
        push(2'd1, 4'h5);
        push(2'd2, 4'h0);
        push(2'd3, 4'h9);
        #1;
        check("edge_gnt_a", gnt_a, 1);
        step();
        req_a = 1'b0;
        check("edge_an_old", an, 4'h7);
        check("edge_bcd_old", bcd, 4'h0);
        for (int k = 0; k < 4 * (BLANK + DIV); k++) step();
        check("edge_an_new", an, 4'h7);
        check("edge_bcd_new", bcd, 4'h9);
        wait_drain(5);

        // Drop en mid-SHOW of digit 3.
        step();
        en = 1'b0;
        step();
        check("dis_an", an, 4'hF);
        check("dis_scan_idx", scan_idx, 0);
        check("dis_bcd_held", bcd, 4'h9);
        // Pointer sits with B after A's last grant and idle cycles.
        step();
        req_a = 1'b1; addr_a = 2'd0; data_a = 4'h3;
        req_b = 1'b1; addr_b = 2'd1; data_b = 4'h5;
        #1;
        check("ptr_gnt_b", gnt_b, 1);
        check("ptr_gnt_a", gnt_a, 0);
        step();
        req_a = 1'b0; req_b = 1'b0;
        check("idle_an", an, 4'hF);
        en = 1'b1;
        push(2'd0, 4'h3);
        step();
        check("reen_an_1", an, 4'hF);
        step();
        check("reen_an_2", an, 4'hF);
        step();
        check("reen_an_3", an, 4'hE);
        check("reen_scan_idx", scan_idx, 0);
        wait_drain(5);

        // Hand priority to B, then reset mid-SHOW with both requests pending.
        req_a = 1'b1; addr_a = 2'd1; data_a = 4'h6;
        #1;
        check("pre_rst_gnt_a", gnt_a, 1);
        step();
        rst = 1'b1;
        req_a = 1'b1; addr_a = 2'd0; data_a = 4'hA;
        req_b = 1'b1; addr_b = 2'd2; data_b = 4'hB;
        #1;
        check("rst_mid_gnt_a", gnt_a, 0);
        check("rst_mid_gnt_b", gnt_b, 0);
        push(2'd0, 4'h1);
        push(2'd1, 4'h0);
        push(2'd2, 4'h0);
        push(2'd3, 4'h2);
        step();
        check("rst_mid_an", an, 4'hF);
        check("rst_mid_scan_idx", scan_idx, 0);
        check("rst_mid_bcd", bcd, 0);
        rst = 1'b0;
        req_a = 1'b1; addr_a = 2'd0; data_a = 4'h1;
        req_b = 1'b1; addr_b = 2'd3; data_b = 4'h2;
        #1;
        check("post_rst_gnt_a", gnt_a, 1);
        check("post_rst_gnt_b", gnt_b, 0);
        step();
        req_a = 1'b0;
        #1;
        check("post_rst_held_gnt_b", gnt_b, 1);
        step();
        req_b = 1'b0;
        wait_drain(60);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: DIV, default 50000, SHOW dwell length in clk cycles per digit; legal range 1..65535.
REQ-002 Parameter: BLANK, default 2, all-anodes-off gap in clk cycles before each digit; legal range 1..255.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: en  input  1  scan enable; low forces display off.
REQ-006 Port: req_a  input  1  requester A write request.
REQ-007 Port: addr_a  input  2  requester A target digit 0..3.
REQ-008 Port: data_a  input  4  requester A BCD nibble.
REQ-009 Port: gnt_a  output  1  combinational grant to A; write to the digit register occurs on the edge closing the cycle.
REQ-010 Port: req_b, addr_b, data_b, gnt_b  same widths, directions and meaning as REQ-006..REQ-009, for requester B.
REQ-011 Port: an  output  4  active-low digit anodes; bit i drives digit i.
REQ-012 Port: bcd  output  4  registered nibble for the active digit, feeding the BCD-to-segment decoder.
REQ-013 Port: scan_idx  output  2  index of the digit currently in BLANK or SHOW.

Function
REQ-014 Four 4-bit digit registers regs[0..3] SHALL hold display content, written only through grants.
REQ-015 Arbitration: only one requester asserting req SHALL be granted in that cycle; neither asserting SHALL give gnt_a=gnt_b=0.
REQ-016 Both requesting in one cycle: the holder of the priority pointer SHALL be granted; the other SHALL see gnt=0 and SHALL hold its request.
REQ-017 Priority pointer SHALL move to the non-granted requester after every grant; it SHALL be unchanged in cycles with no grant.
REQ-018 At most one register write per cycle; gnt SHALL never be asserted without its req.
REQ-019 Arbitration and writes SHALL operate independently of en and of scan state.
REQ-020 FSM states: IDLE, BLANK, SHOW.
REQ-021 IDLE: an=4'b1111; scan_idx=0; en=1 SHALL move to BLANK on the next edge with the cycle counter cleared.
REQ-022 BLANK: an=4'b1111 for exactly BLANK cycles, then transition to SHOW.
REQ-023 BLANK->SHOW edge: bcd SHALL load regs[scan_idx]; a same-edge write to that register SHALL NOT be visible (pre-write value loaded); the new value appears on the next visit.
REQ-024 SHOW: an SHALL have only bit scan_idx low, for exactly DIV cycles; then scan_idx SHALL increment, wrapping 3->0, and the FSM SHALL return to BLANK.
REQ-025 an SHALL be decoded from registered state and scan_idx only; never two bits low.
REQ-026 en=0 in BLANK or SHOW SHALL force IDLE on the next edge: counter cleared, scan_idx=0, bcd held.
REQ-027 Full-scan period SHALL be 4*(BLANK+DIV) cycles; the cycle counter SHALL be at least 16 bits wide and SHALL never wrap within a phase.

Reset
REQ-028 rst=1 at an edge SHALL set state=IDLE, counter=0, scan_idx=0, an=4'b1111, bcd=0, regs[0..3]=0, priority pointer=A.
REQ-029 rst SHALL override en and all requests; no write SHALL occur on a reset edge; gnt_a=gnt_b=0 while rst=1.
REQ-030 Reset asserted mid-SHOW SHALL blank an in the following cycle and restart scanning from digit 0 after release with en=1.

Verification (DIV=4, BLANK=2)
REQ-031 Reset then en=1: an shows 1111 for 1 IDLE cycle plus 2 BLANK cycles, then 1110 for 4 cycles, 1111 for 2, then 1101; bcd=0.
REQ-032 A writes addr 2 data 7 only: gnt_a=1 same cycle; on the next digit-2 SHOW, an=1011 and bcd=7.
REQ-033 A (addr 0, data 3) and B (addr 1, data 5) requesting together after reset: gnt_a=1, gnt_b=0; next cycle gnt_b=1; scan shows digit 0 = 3 and digit 1 = 5.
REQ-034 Write to regs[scan_idx] on the BLANK->SHOW edge: bcd shows the old value this visit and the new value after 4*(2+4)=24 cycles.
REQ-035 en dropped mid-SHOW of digit 3: an=1111 the next cycle, scan_idx=0; re-enable restarts at digit 0 after 2 BLANK cycles.
REQ-036 rst pulsed during SHOW with pending writes from both requesters: all regs=0, no grant that cycle, pointer=A afterwards.
